// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract controller.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sac_state_t;

  localparam int unsigned SAC_WIDTH_DEFAULT = 8;

  function automatic int unsigned sac_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned SAC_CNT_W = sac_cnt_width(SAC_WIDTH_DEFAULT);

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell shared across all bit positions.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first,
// start/busy/done handshake with registered results.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SAC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned     CW       = sac_cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  sac_state_t       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;

  fa_bit u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert B on load and force carry-in.
            r_a_sr  <= a;
            r_b_sr  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res_sr <= {w_s, r_res_sr[WIDTH-1:1]};
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_carry  <= w_co;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            // r_carry is the carry into the MSB; w_co is the carry out of it.
            sum      <= {w_s, r_res_sr[WIDTH-1:1]};
            cout     <= w_co;
            overflow <= r_carry ^ w_co;
            done     <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [W+1:0] prev_res;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {overflow, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s, input logic c);
    longint modv, half, ux, uy, sx, sy, full, r, res;
    logic   co, ov;
    modv = longint'(1) << W;
    half = longint'(1) << (W - 1);
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = (ux >= half) ? ux - modv : ux;
    sy   = (uy >= half) ? uy - modv : uy;
    if (!s) begin
      full = ux + uy + longint'(c);
      co   = (full >= modv);
      r    = sx + sy + longint'(c);
    end else begin
      full = ux - uy;
      co   = (ux >= uy);
      r    = sx - sy;
    end
    res = ((full % modv) + modv) % modv;
    ov  = (r >= half) || (r < -half);
    return {ov, co, res[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [W+1:0] e);
    chk({tag, "_sum"}, 64'(sum), 64'(e[W-1:0]));
    chk({tag, "_cout"}, 64'(cout), 64'(e[W]));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e[W+1]));
  endtask

  // Runs one operation; intr fires ignored starts mid-run and in DONE,
  // hold keeps start asserted throughout for back-to-back issue.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic c, input bit intr, input bit hold);
    logic [W+1:0] e;
    e     = ref_op(x, y, s, c);
    a     = x;
    b     = y;
    sub   = s;
    cin   = c;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= W + 1; k++) begin
      chk("busy_run", 64'(busy), 64'(1));
      chk("done_pulse", 64'(done), 64'(k == W + 1));
      if (k <= W) chk_res("held", prev_res);
      else        chk_res("result", e);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      start = hold || (intr && (k == 3 || k == W + 1));
      @(posedge clk); #1;
    end
    prev_res = e;
    chk("busy_idle", 64'(busy), 64'(0));
    chk("done_idle", 64'(done), 64'(0));
    chk_res("after", e);
    if (!hold) start = 1'b0;
    if (intr) begin
      @(posedge clk); #1;
      chk("busy_ignored", 64'(busy), 64'(0));
      chk("done_ignored", 64'(done), 64'(0));
      chk_res("ignored", e);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    cin      = 1'b0;
    a        = '0;
    b        = '0;
    prev_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk_res("rst", '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_5a_3c", 64'({overflow, cout, sum}), 64'({1'b1, 1'b0, 8'h96}));
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_ff_01", 64'({overflow, cout, sum}), 64'({1'b0, 1'b1, 8'h00}));
    run_op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tp_cin", 64'(sum), 64'(8'h01));
    run_op(8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_sub_10_01", 64'({overflow, cout, sum}), 64'({1'b0, 1'b1, 8'h0F}));
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp_sub_80_01", 64'({overflow, cout, sum}), 64'({1'b1, 1'b1, 8'h7F}));
    run_op(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_borrow", 64'({cout, sum}), 64'({1'b0, 8'hFF}));

    run_op(8'h21, 8'h43, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);

    // Abort mid-run with asynchronous reset.
    a     = 8'h77;
    b     = 8'h11;
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk_res("abort", '0);
    @(posedge clk); #1;
    chk("abort_hold_busy", 64'(busy), 64'(0));
    chk("abort_hold_done", 64'(done), 64'(0));
    rst_n    = 1'b1;
    prev_res = '0;
    @(posedge clk); #1;
    run_op(8'h77, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);

    for (int i = 0; i < 5; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("b2b_end_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
